// File: rtl/l1_fill_ctrl_pkg.sv
// Shared constants for the L1 miss-fill controller: cache geometry and FSM encoding.
package l1_fill_ctrl_pkg;

   // Cache geometry
   localparam int unsigned L1_CACHE_NUM_WAYS     = 4;
   localparam int unsigned L1_CACHE_NUM_WAYS_LOG = 2;
   localparam int unsigned L1_CACHE_NUM_SETS     = 64;
   localparam int unsigned L1_CACHE_NUM_SETS_LOG = 6;
   localparam int unsigned L1_TAG_WIDTH          = 20;
   localparam int unsigned L1_LINE_BITS          = 512;
   localparam int unsigned L1_MISS_QUEUE_DEPTH   = 4;

   // Fill FSM state encoding
   localparam logic [2:0] FILL_IDLE     = 3'd0;
   localparam logic [2:0] FILL_REQ      = 3'd1;
   localparam logic [2:0] FILL_WAIT_RSP = 3'd2;
   localparam logic [2:0] FILL_LRU      = 3'd3;
   localparam logic [2:0] FILL_WAY      = 3'd4;
   localparam logic [2:0] FILL_WRITE    = 3'd5;

endpackage

// File: rtl/l1_fill_ctrl_miss_fifo.sv
// Miss queue: FIFO of {tag,set} entries with a parallel match port used to merge duplicate misses.
module l1_fill_ctrl_miss_fifo
   import l1_fill_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = L1_MISS_QUEUE_DEPTH,
   parameter int unsigned WIDTH = L1_TAG_WIDTH + L1_CACHE_NUM_SETS_LOG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_data,
   output logic             o_full,
   output logic             o_empty,
   input  logic [WIDTH-1:0] i_match_data,
   output logic             o_match
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] w_vld_nxt;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full      = (r_count == CNT_W'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_head_data = r_mem[r_rd_ptr];

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign w_push = i_push & (~o_full | i_pop);
   assign w_pop  = i_pop & ~o_empty;

   // Per-entry valid bits: clear on pop first, so a same-slot push (full queue) wins.
   always_comb begin
      w_vld_nxt = r_vld;
      if (w_pop) w_vld_nxt[r_rd_ptr] = 1'b0;
      if (w_push) w_vld_nxt[r_wr_ptr] = 1'b1;
   end

   // Compare the incoming miss against every live entry.
   always_comb begin
      o_match = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (r_vld[i] && (r_mem[i] == i_match_data)) o_match = 1'b1;
      end
   end

   // Pointers, occupancy count and valid bits; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_vld    <= '0;
      end else begin
         r_vld <= w_vld_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/l1_fill_ctrl.sv
// L1 miss-fill controller: queues misses, fetches one line at a time from memory, asks the
// replacement unit for a victim way and writes tag+data into the arrays.
module l1_fill_ctrl
   import l1_fill_ctrl_pkg::*;
#(
   parameter int unsigned NUM_WAYS    = L1_CACHE_NUM_WAYS,
   parameter int unsigned NUM_SETS    = L1_CACHE_NUM_SETS,
   parameter int unsigned TAG_WIDTH   = L1_TAG_WIDTH,
   parameter int unsigned LINE_BITS   = L1_LINE_BITS,
   parameter int unsigned QUEUE_DEPTH = L1_MISS_QUEUE_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   i_miss_valid,
   output logic                                   o_miss_ready,
   input  logic [$clog2(NUM_SETS)-1:0]            i_miss_set,
   input  logic [TAG_WIDTH-1:0]                   i_miss_tag,
   output logic                                   o_mem_req_valid,
   input  logic                                   i_mem_req_ready,
   output logic [TAG_WIDTH+$clog2(NUM_SETS)-1:0]  o_mem_req_addr,
   input  logic                                   i_mem_rsp_valid,
   input  logic [LINE_BITS-1:0]                   i_mem_rsp_data,
   output logic                                   o_fill_en,
   output logic [$clog2(NUM_SETS)-1:0]            o_fill_set,
   input  logic [$clog2(NUM_WAYS)-1:0]            i_fill_way_idx,
   output logic                                   o_wr_en,
   output logic [$clog2(NUM_SETS)-1:0]            o_wr_set,
   output logic [$clog2(NUM_WAYS)-1:0]            o_wr_way,
   output logic [TAG_WIDTH-1:0]                   o_wr_tag,
   output logic [LINE_BITS-1:0]                   o_wr_data,
   output logic                                   o_fill_done
);

   localparam int unsigned SET_W = $clog2(NUM_SETS);
   localparam int unsigned WAY_W = $clog2(NUM_WAYS);
   localparam int unsigned ENT_W = TAG_WIDTH + SET_W;

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic [ENT_W-1:0]     r_infl;        // in-flight line, {tag,set}
   logic                 r_infl_valid;
   logic [LINE_BITS-1:0] r_data;
   logic [WAY_W-1:0]     r_way;

   logic [ENT_W-1:0]     w_miss_entry;
   logic [ENT_W-1:0]     w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_fifo_match;
   logic                 w_infl_match;
   logic                 w_deq;
   logic                 w_accept;
   logic                 w_push;

   assign w_miss_entry = {i_miss_tag, i_miss_set};
   assign w_deq        = (r_state == FILL_IDLE) & ~w_empty;

   // The dequeue frees a slot this cycle, so a full queue can still take a miss then.
   assign o_miss_ready = ~w_full | w_deq;
   assign w_accept     = i_miss_valid & o_miss_ready;
   assign w_infl_match = r_infl_valid & (r_infl == w_miss_entry);
   // Duplicates of a queued or in-flight line are accepted and dropped.
   assign w_push       = w_accept & ~w_fifo_match & ~w_infl_match;

   l1_fill_ctrl_miss_fifo #(
      .DEPTH(QUEUE_DEPTH),
      .WIDTH(ENT_W)
   ) u_miss_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data (w_miss_entry),
      .i_pop       (w_deq),
      .o_head_data (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .i_match_data(w_miss_entry),
      .o_match     (w_fifo_match)
   );

   // Next-state logic of the fill sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL_IDLE:     if (!w_empty) w_state_nxt = FILL_REQ;
         FILL_REQ:      if (i_mem_req_ready) w_state_nxt = FILL_WAIT_RSP;
         FILL_WAIT_RSP: if (i_mem_rsp_valid) w_state_nxt = FILL_LRU;
         FILL_LRU:      w_state_nxt = FILL_WAY;
         FILL_WAY:      w_state_nxt = FILL_WRITE;
         FILL_WRITE:    w_state_nxt = FILL_IDLE;
         default:       w_state_nxt = FILL_IDLE;
      endcase
   end

   // State register; reset drops any outstanding fetch so late responses land in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= FILL_IDLE;
      else        r_state <= w_state_nxt;
   end

   // In-flight line tracking: valid for merging from dequeue through the write cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_infl       <= '0;
         r_infl_valid <= 1'b0;
      end else if (w_deq) begin
         r_infl       <= w_head;
         r_infl_valid <= 1'b1;
      end else if (r_state == FILL_WRITE) begin
         r_infl_valid <= 1'b0;
      end
   end

   // Capture returned line data and the victim way chosen by the replacement unit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_way  <= '0;
      end else begin
         if ((r_state == FILL_WAIT_RSP) && i_mem_rsp_valid) r_data <= i_mem_rsp_data;
         if (r_state == FILL_WAY) r_way <= i_fill_way_idx;
      end
   end

   // Output decode; address/set/tag fields come straight from the in-flight register.
   always_comb begin
      o_mem_req_valid = (r_state == FILL_REQ);
      o_mem_req_addr  = r_infl;
      o_fill_en       = (r_state == FILL_LRU);
      o_fill_set      = r_infl[SET_W-1:0];
      o_wr_en         = (r_state == FILL_WRITE);
      o_fill_done     = (r_state == FILL_WRITE);
      o_wr_set        = r_infl[SET_W-1:0];
      o_wr_tag        = r_infl[ENT_W-1:SET_W];
      o_wr_way        = r_way;
      o_wr_data       = r_data;
   end

endmodule

// File: tb/tb_l1_fill_ctrl.sv
// Directed self-checking bench for l1_fill_ctrl with a memory responder and a tree-PLRU model.
module tb_l1_fill_ctrl;
   import l1_fill_ctrl_pkg::*;

   localparam int SW = 6;
   localparam int WW = 2;
   localparam int TW = 20;
   localparam int LB = 512;
   localparam int AW = TW + SW;

   localparam int S_REQ   = 0;
   localparam int S_FILL  = 1;
   localparam int S_READY = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_miss_valid;
   logic          o_miss_ready;
   logic [SW-1:0] i_miss_set;
   logic [TW-1:0] i_miss_tag;
   logic          o_mem_req_valid;
   logic          i_mem_req_ready;
   logic [AW-1:0] o_mem_req_addr;
   logic          i_mem_rsp_valid;
   logic [LB-1:0] i_mem_rsp_data;
   logic          o_fill_en;
   logic [SW-1:0] o_fill_set;
   logic [WW-1:0] i_fill_way_idx;
   logic          o_wr_en;
   logic [SW-1:0] o_wr_set;
   logic [WW-1:0] o_wr_way;
   logic [TW-1:0] o_wr_tag;
   logic [LB-1:0] o_wr_data;
   logic          o_fill_done;

   always #5 clk = ~clk;

   l1_fill_ctrl u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_miss_valid   (i_miss_valid),
      .o_miss_ready   (o_miss_ready),
      .i_miss_set     (i_miss_set),
      .i_miss_tag     (i_miss_tag),
      .o_mem_req_valid(o_mem_req_valid),
      .i_mem_req_ready(i_mem_req_ready),
      .o_mem_req_addr (o_mem_req_addr),
      .i_mem_rsp_valid(i_mem_rsp_valid),
      .i_mem_rsp_data (i_mem_rsp_data),
      .o_fill_en      (o_fill_en),
      .o_fill_set     (o_fill_set),
      .i_fill_way_idx (i_fill_way_idx),
      .o_wr_en        (o_wr_en),
      .o_wr_set       (o_wr_set),
      .o_wr_way       (o_wr_way),
      .o_wr_tag       (o_wr_tag),
      .o_wr_data      (o_wr_data),
      .o_fill_done    (o_fill_done)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Stimulus-controlled knobs
   int            rsp_delay = 4;
   logic [LB-1:0] rsp_data  = '0;
   logic          stray_rsp = 1'b0;
   logic          use_lru   = 1'b0;
   logic [WW-1:0] force_way = '0;

   // Memory responder: one response pulse rsp_delay cycles after each request handshake.
   logic model_rsp = 1'b0;
   logic rsp_pend  = 1'b0;
   int   rsp_cnt   = 0;
   always @(posedge clk) begin
      model_rsp <= 1'b0;
      if (!rst_n) begin
         rsp_pend <= 1'b0;
      end else if (o_mem_req_valid && i_mem_req_ready) begin
         rsp_pend <= 1'b1;
         rsp_cnt  <= rsp_delay;
      end else if (rsp_pend) begin
         if (rsp_cnt <= 1) begin
            model_rsp <= 1'b1;
            rsp_pend  <= 1'b0;
         end else begin
            rsp_cnt <= rsp_cnt - 1;
         end
      end
   end
   assign i_mem_rsp_valid = model_rsp | stray_rsp;
   assign i_mem_rsp_data  = rsp_data;

   // Tree-PLRU replacement model; victim returned the cycle after fill_en is sampled.
   function automatic logic [1:0] plru_victim(input logic [2:0] b);
      return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
   endfunction
   function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
      logic [2:0] r;
      r = b;
      if (!w[1]) begin
         r[0] = 1'b1;
         r[1] = ~w[0];
      end else begin
         r[0] = 1'b0;
         r[2] = ~w[0];
      end
      return r;
   endfunction

   logic [2:0]    plru [64] = '{default: 3'b000};
   logic [WW-1:0] lru_way   = '0;
   always @(posedge clk) begin
      if (o_fill_en) begin
         lru_way          <= plru_victim(plru[o_fill_set]);
         plru[o_fill_set] <= plru_touch(plru[o_fill_set], plru_victim(plru[o_fill_set]));
      end
   end
   assign i_fill_way_idx = use_lru ? lru_way : force_way;

   // Event monitors
   int         req_cnt  = 0;
   int         fe_cnt   = 0;
   int         wr_cnt   = 0;
   int         done_cnt = 0;
   logic [1:0] way_log[$];
   always @(posedge clk) begin
      if (o_mem_req_valid && i_mem_req_ready) req_cnt <= req_cnt + 1;
      if (o_fill_en) fe_cnt <= fe_cnt + 1;
      if (o_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         way_log.push_back(o_wr_way);
      end
      if (o_fill_done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig_of(input int which);
      case (which)
         S_REQ:   return o_mem_req_valid;
         S_FILL:  return o_fill_en;
         default: return o_miss_ready;
      endcase
   endfunction

   // Bounded wait (at negedges) for a DUT output to go high; timing out is a failed check.
   task automatic wait_for(input int which, input int max, input string tag);
      int k;
      k = 0;
      while (!sig_of(which) && k < max) begin
         tick();
         k++;
      end
      chk(tag, sig_of(which), 1'b1);
   endtask

   task automatic wait_done(input int target, input int max, input string tag);
      for (int k = 0; k < max && done_cnt < target; k++) tick();
      chk(tag, done_cnt, target);
   endtask

   task automatic send_miss(input logic [SW-1:0] s, input logic [TW-1:0] t, input string tag);
      i_miss_valid = 1'b1;
      i_miss_set   = s;
      i_miss_tag   = t;
      chk(tag, o_miss_ready, 1'b1);
      tick();
      i_miss_valid = 1'b0;
   endtask

   int         base_req;
   int         base_done;
   int         base_fe;
   int         base_wr;
   int         wb;
   logic [1:0] exp_ways [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
   logic [1:0] got_way;

   initial begin
      rst_n           = 1'b0;
      i_miss_valid    = 1'b0;
      i_miss_set      = '0;
      i_miss_tag      = '0;
      i_mem_req_ready = 1'b0;
      tick(3);
      rst_n = 1'b1;

      // Reset state
      chk("rst_miss_ready", o_miss_ready, 1'b1);
      chk("rst_req_valid", o_mem_req_valid, 1'b0);
      chk("rst_fill_en", o_fill_en, 1'b0);
      chk("rst_wr_en", o_wr_en, 1'b0);
      chk("rst_fill_done", o_fill_done, 1'b0);
      chk("rst_req_addr", o_mem_req_addr, '0);
      chk("rst_wr_data", o_wr_data, '0);
      tick();

      // Single miss
      rsp_data        = {64{8'hA5}};
      force_way       = 2'd2;
      rsp_delay       = 4;
      i_mem_req_ready = 1'b1;
      send_miss(6'h3, 20'h12345, "t1_accept");
      wait_for(S_REQ, 10, "t1_req_seen");
      chk("t1_req_addr", o_mem_req_addr, {20'h12345, 6'h3});
      wait_for(S_FILL, 30, "t1_fill_en_seen");
      chk("t1_fill_set", o_fill_set, 6'h3);
      chk("t1_no_wr_at_lru", o_wr_en, 1'b0);
      tick();
      chk("t1_fill_en_one_cycle", o_fill_en, 1'b0);
      chk("t1_no_wr_at_way", o_wr_en, 1'b0);
      tick();
      chk("t1_wr_en", o_wr_en, 1'b1);
      chk("t1_wr_way", o_wr_way, 2'd2);
      chk("t1_wr_set", o_wr_set, 6'h3);
      chk("t1_wr_tag", o_wr_tag, 20'h12345);
      chk("t1_wr_data", o_wr_data, {64{8'hA5}});
      chk("t1_fill_done", o_fill_done, 1'b1);
      tick();
      chk("t1_wr_en_drop", o_wr_en, 1'b0);
      chk("t1_done_drop", o_fill_done, 1'b0);

      // Merge: duplicate while queued, then again while in flight
      base_req     = req_cnt;
      base_done    = done_cnt;
      force_way    = 2'd1;
      rsp_data     = {16{32'hDEAD_BEEF}};
      send_miss(6'h5, 20'hABCDE, "mg_accept0");
      send_miss(6'h5, 20'hABCDE, "mg_accept1");
      wait_for(S_REQ, 10, "mg_req_seen");
      tick();
      send_miss(6'h5, 20'hABCDE, "mg_accept_inflight");
      tick(20);
      chk("mg_one_request", req_cnt - base_req, 1);
      chk("mg_one_done", done_cnt - base_done, 1);
      chk("mg_queue_drained", o_mem_req_valid, 1'b0);

      // Full queue with memory stalled
      i_mem_req_ready = 1'b0;
      base_req        = req_cnt;
      base_done       = done_cnt;
      for (int i = 0; i < 5; i++) begin
         i_miss_valid = 1'b1;
         i_miss_set   = 6'(8 + i);
         i_miss_tag   = 20'(32'h100 + i);
         chk("full_fill_accept", o_miss_ready, 1'b1);
         tick();
      end
      i_miss_set = 6'd13;
      i_miss_tag = 20'h105;
      chk("full_ready_low", o_miss_ready, 1'b0);
      chk("full_req_stalled", o_mem_req_valid, 1'b1);
      tick(3);
      chk("full_ready_still_low", o_miss_ready, 1'b0);
      i_mem_req_ready = 1'b1;
      wait_for(S_READY, 60, "full_deq_ready");
      chk("full_deq_in_idle", o_mem_req_valid, 1'b0);
      tick();
      i_miss_valid = 1'b0;
      chk("full_next_req", o_mem_req_valid, 1'b1);
      chk("full_next_addr", o_mem_req_addr, {20'h101, 6'd9});
      chk("full_count_kept", o_miss_ready, 1'b0);
      wait_done(base_done + 6, 400, "full_all_done");
      chk("full_req_count", req_cnt - base_req, 6);

      // LRU sweep on set 0
      use_lru   = 1'b1;
      rsp_delay = 2;
      wb        = way_log.size();
      for (int i = 0; i < 5; i++) send_miss(6'd0, 20'(32'h200 + i), "lru_accept");
      for (int k = 0; k < 300 && way_log.size() < wb + 5; k++) tick();
      chk("lru_fill_count", way_log.size() - wb, 5);
      for (int i = 0; i < 5; i++) begin
         got_way = (way_log.size() > wb + i) ? way_log[wb + i] : 2'bxx;
         chk($sformatf("lru_way%0d", i), got_way, exp_ways[i]);
      end

      // Request backpressure
      use_lru         = 1'b0;
      force_way       = 2'd3;
      rsp_delay       = 4;
      i_mem_req_ready = 1'b0;
      base_fe         = fe_cnt;
      base_done       = done_cnt;
      send_miss(6'd9, 20'h09999, "bp_accept");
      wait_for(S_REQ, 10, "bp_req_seen");
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid_held", o_mem_req_valid, 1'b1);
         chk("bp_addr_held", o_mem_req_addr, {20'h09999, 6'd9});
         chk("bp_no_fill_en", o_fill_en, 1'b0);
         tick();
      end
      chk("bp_fill_en_count", fe_cnt - base_fe, 0);
      i_mem_req_ready = 1'b1;
      wait_done(base_done + 1, 60, "bp_done");

      // Reset while waiting for the response, then a stray response
      rsp_delay = 8;
      send_miss(6'd10, 20'h0AAAA, "rs_accept");
      wait_for(S_REQ, 10, "rs_req_seen");
      tick();
      chk("rs_in_wait", o_mem_req_valid, 1'b0);
      base_fe = fe_cnt;
      base_wr = wr_cnt;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick();
      stray_rsp = 1'b1;
      tick();
      stray_rsp = 1'b0;
      tick(12);
      chk("rs_no_fill_en", fe_cnt - base_fe, 0);
      chk("rs_no_wr_en", wr_cnt - base_wr, 0);
      chk("rs_miss_ready", o_miss_ready, 1'b1);
      chk("rs_no_req", o_mem_req_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
